// File: rtl/aes_seq_pkg.sv
// Shared definitions for the aes block sequencer: core register map, control/status bit
// positions, bus widths and the sequencer state encoding.
package aes_seq_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned KEY_W  = 256;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DLY_W  = 4;

    localparam logic [ADDR_W-1:0] ADDR_CTRL    = 8'h08;
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = 8'h09;
    localparam logic [ADDR_W-1:0] ADDR_CONFIG  = 8'h0A;
    localparam logic [ADDR_W-1:0] ADDR_KEY0    = 8'h10;
    localparam logic [ADDR_W-1:0] ADDR_BLOCK0  = 8'h20;
    localparam logic [ADDR_W-1:0] ADDR_RESULT0 = 8'h30;

    localparam int unsigned CTRL_INIT_BIT     = 0;
    localparam int unsigned CTRL_NEXT_BIT     = 1;
    localparam int unsigned STATUS_READY_BIT  = 0;
    localparam int unsigned CONFIG_ENCDEC_BIT = 0;
    localparam int unsigned CONFIG_KEYLEN_BIT = 1;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_KEY_CFG  = 4'd1,
        S_KEY_WR   = 4'd2,
        S_KEY_INIT = 4'd3,
        S_KEY_WAIT = 4'd4,
        S_KEY_POLL = 4'd5,
        S_BLK_WR   = 4'd6,
        S_BLK_NEXT = 4'd7,
        S_BLK_WAIT = 4'd8,
        S_BLK_POLL = 4'd9,
        S_RES_RD   = 4'd10,
        S_OUT      = 4'd11
    } seq_state_e;

    typedef struct packed {
        logic              cs;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/aes_block_sequencer_if.sv
// Register port of the aes core: the sequencer is the master, the core is the slave.
interface aes_block_sequencer_if;
    import aes_seq_pkg::*;

    logic              aes_cs;
    logic              aes_we;
    logic [ADDR_W-1:0] aes_address;
    logic [DATA_W-1:0] aes_write_data;
    logic [DATA_W-1:0] aes_read_data;

    modport master (
        output aes_cs, aes_we, aes_address, aes_write_data,
        input  aes_read_data
    );

    modport slave (
        input  aes_cs, aes_we, aes_address, aes_write_data,
        output aes_read_data
    );

endinterface

// File: rtl/aes_block_sequencer.sv
// Autonomous master for the aes core register port: loads key/config, runs init, then processes
// one 128-bit block at a time. Define AES_SEQ_TIMEOUT_EN to bound each status poll phase.
module aes_block_sequencer
    import aes_seq_pkg::*;
#(
    parameter int unsigned POLL_DELAY     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [KEY_W-1:0]      key,
    input  logic                  key_len,
    input  logic                  enc_dec,
    input  logic                  blk_in_valid,
    output logic                  blk_in_ready,
    input  logic [BLK_W-1:0]      blk_in_data,
    output logic                  blk_out_valid,
    input  logic                  blk_out_ready,
    output logic [BLK_W-1:0]      blk_out_data,
    aes_block_sequencer_if.master bus,
    output logic                  key_loaded,
    output logic                  busy,
    output logic                  error
);

    if (POLL_DELAY == 0 || POLL_DELAY > 15) begin : g_bad_poll_delay
        $error("aes_block_sequencer: POLL_DELAY must be 1..15");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("aes_block_sequencer: TIMEOUT_CYCLES must be nonzero");
    end

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              key_len_q, key_len_d;
    logic              enc_dec_q, enc_dec_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [BLK_W-1:0]  res_q, res_d;
    bus_req_t          bus_q, bus_d;
    logic              key_ready_q, key_ready_d;
    logic              blk_in_ready_q, blk_in_ready_d;
    logic              blk_out_valid_q, blk_out_valid_d;
    logic              key_loaded_q, key_loaded_d;
    logic              busy_q, busy_d;
    logic              key_hs, blk_hs, status_ready;

`ifdef AES_SEQ_TIMEOUT_EN
    localparam int unsigned POLL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [POLL_W-1:0] poll_q, poll_d;
    logic              error_q, error_d;
`endif

    function automatic logic [DATA_W-1:0] key_word(input logic [KEY_W-1:0] k,
                                                   input logic [CNT_W-1:0] idx);
        return k[KEY_W-1-DATA_W*int'(idx) -: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] blk_word(input logic [BLK_W-1:0] b,
                                                   input logic [1:0] idx);
        return b[BLK_W-1-DATA_W*int'(idx) -: DATA_W];
    endfunction

    // A pending key wins over a pending block in the same IDLE cycle.
    assign blk_in_ready  = blk_in_ready_q & ~key_valid;
    assign key_ready     = key_ready_q;
    assign blk_out_valid = blk_out_valid_q;
    assign blk_out_data  = res_q;
    assign key_loaded    = key_loaded_q;
    assign busy          = busy_q;
    assign key_hs        = key_valid & key_ready_q;
    assign blk_hs        = blk_in_valid & blk_in_ready;
    assign status_ready  = bus.aes_read_data[STATUS_READY_BIT];

    assign bus.aes_cs         = bus_q.cs;
    assign bus.aes_we         = bus_q.we;
    assign bus.aes_address    = bus_q.addr;
    assign bus.aes_write_data = bus_q.wdata;

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dly_d        = dly_q;
        key_d        = key_q;
        key_len_d    = key_len_q;
        enc_dec_d    = enc_dec_q;
        blk_d        = blk_q;
        res_d        = res_q;
        key_loaded_d = key_loaded_q;
`ifdef AES_SEQ_TIMEOUT_EN
        poll_d       = poll_q;
        error_d      = error_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (key_hs) begin
                    key_d        = key;
                    key_len_d    = key_len;
                    enc_dec_d    = enc_dec;
                    key_loaded_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = S_KEY_CFG;
                end else if (blk_hs) begin
                    blk_d   = blk_in_data;
                    cnt_d   = '0;
                    state_d = S_BLK_WR;
                end
            end
            S_KEY_CFG: begin
                cnt_d   = '0;
                state_d = S_KEY_WR;
            end
            S_KEY_WR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(7)) state_d = S_KEY_INIT;
            end
            S_KEY_INIT, S_BLK_NEXT: begin
                dly_d   = '0;
                state_d = (state_q == S_KEY_INIT) ? S_KEY_WAIT : S_BLK_WAIT;
            end
            S_KEY_WAIT, S_BLK_WAIT: begin
                dly_d = dly_q + DLY_W'(1);
                if (dly_q == DLY_W'(POLL_DELAY - 1)) begin
                    state_d = (state_q == S_KEY_WAIT) ? S_KEY_POLL : S_BLK_POLL;
`ifdef AES_SEQ_TIMEOUT_EN
                    poll_d  = '0;
`endif
                end
            end
            S_KEY_POLL, S_BLK_POLL: begin
                if (status_ready) begin
                    cnt_d = '0;
                    if (state_q == S_KEY_POLL) begin
                        key_loaded_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_RES_RD;
                    end
                end
`ifdef AES_SEQ_TIMEOUT_EN
                else if (poll_q == POLL_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    poll_d = poll_q + POLL_W'(1);
                end
`endif
            end
            S_BLK_WR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(3)) begin
                    cnt_d   = '0;
                    state_d = S_BLK_NEXT;
                end
            end
            S_RES_RD: begin
                res_d = {res_q[BLK_W-DATA_W-1:0], bus.aes_read_data};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(3)) begin
                    cnt_d   = '0;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (blk_out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        key_ready_d     = (state_d == S_IDLE);
        blk_in_ready_d  = (state_d == S_IDLE) && key_loaded_d;
        blk_out_valid_d = (state_d == S_OUT);
        busy_d          = (state_d != S_IDLE);
    end

    // Bus request for the cycle the FSM is about to enter, so the bus outputs stay registered.
    always_comb begin
        bus_d = '0;
        case (state_d)
            S_KEY_CFG: begin
                bus_d.cs                       = 1'b1;
                bus_d.we                       = 1'b1;
                bus_d.addr                     = ADDR_CONFIG;
                bus_d.wdata[CONFIG_ENCDEC_BIT] = enc_dec_d;
                bus_d.wdata[CONFIG_KEYLEN_BIT] = key_len_d;
            end
            S_KEY_WR: begin
                bus_d.cs    = 1'b1;
                bus_d.we    = 1'b1;
                bus_d.addr  = ADDR_KEY0 | ADDR_W'(cnt_d);
                bus_d.wdata = key_word(key_d, cnt_d);
            end
            S_KEY_INIT: begin
                bus_d.cs                   = 1'b1;
                bus_d.we                   = 1'b1;
                bus_d.addr                 = ADDR_CTRL;
                bus_d.wdata[CTRL_INIT_BIT] = 1'b1;
            end
            S_BLK_NEXT: begin
                bus_d.cs                   = 1'b1;
                bus_d.we                   = 1'b1;
                bus_d.addr                 = ADDR_CTRL;
                bus_d.wdata[CTRL_NEXT_BIT] = 1'b1;
            end
            S_KEY_POLL, S_BLK_POLL: begin
                bus_d.cs   = 1'b1;
                bus_d.addr = ADDR_STATUS;
            end
            S_BLK_WR: begin
                bus_d.cs    = 1'b1;
                bus_d.we    = 1'b1;
                bus_d.addr  = ADDR_BLOCK0 | ADDR_W'(cnt_d);
                bus_d.wdata = blk_word(blk_d, cnt_d[1:0]);
            end
            S_RES_RD: begin
                bus_d.cs   = 1'b1;
                bus_d.addr = ADDR_RESULT0 | ADDR_W'(cnt_d);
            end
            default: bus_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            dly_q           <= '0;
            key_q           <= '0;
            key_len_q       <= 1'b0;
            enc_dec_q       <= 1'b0;
            blk_q           <= '0;
            res_q           <= '0;
            bus_q           <= '0;
            key_ready_q     <= 1'b0;
            blk_in_ready_q  <= 1'b0;
            blk_out_valid_q <= 1'b0;
            key_loaded_q    <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            dly_q           <= dly_d;
            key_q           <= key_d;
            key_len_q       <= key_len_d;
            enc_dec_q       <= enc_dec_d;
            blk_q           <= blk_d;
            res_q           <= res_d;
            bus_q           <= bus_d;
            key_ready_q     <= key_ready_d;
            blk_in_ready_q  <= blk_in_ready_d;
            blk_out_valid_q <= blk_out_valid_d;
            key_loaded_q    <= key_loaded_d;
            busy_q          <= busy_d;
        end
    end

`ifdef AES_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_q  <= '0;
            error_q <= 1'b0;
        end else begin
            poll_q  <= poll_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule
